// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states and GF(2^8) helpers for the AES inverse cipher.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [79:0] RCON_TAB = 80'h36_1b_80_40_20_10_08_04_02_01;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'd10) ? RCON_TAB[8*(int'(r)-1) +: 8] : 8'h00;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction
  function automatic logic [7:0] mulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction
  function automatic logic [7:0] muld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction
  function automatic logic [7:0] mule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction
  // Row r rotates right by r columns; byte k sits at [127-8k -: 8], k = 4*col + row.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction
endpackage

// File: rtl/Sbox.sv
// Sbox: FIPS-197 forward AES S-box lookup.
module Sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign out = T[{~in, 3'b000} +: 8];
endmodule

// File: rtl/inv_sbox.sv
// inv_sbox: FIPS-197 inverse AES S-box lookup.
module inv_sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);
  localparam logic [2047:0] T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign out = T[{~in, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES-128 decryption, one inverse round per clock,
// with the key schedule run backwards from the round-10 key.
module aes_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);
  state_t       r_state;
  logic [127:0] r_st, r_rk, r_pt;
  logic [3:0]   r_rnd;
  logic [127:0] w_sr, w_sb, w_ark, w_mix, w_rk_prev;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_n3, w_rot, w_sub;
  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
  assign w_n3  = w_w3 ^ w_w2;
  assign w_rot = {w_n3[23:0], w_n3[31:24]};
  genvar i, c;
  for (i = 0; i < 4; i++) begin : g_ks
    Sbox u_sbox (.in(w_rot[31-8*i -: 8]), .out(w_sub[31-8*i -: 8]));
  end
  assign w_rk_prev = {w_w0 ^ w_sub ^ {rcon(r_rnd), 24'h0}, w_w1 ^ w_w0, w_w2 ^ w_w1, w_n3};
  assign w_sr = inv_shift_rows(r_st);
  for (i = 0; i < 16; i++) begin : g_sb
    inv_sbox u_inv_sbox (.in(w_sr[127-8*i -: 8]), .out(w_sb[127-8*i -: 8]));
  end
  assign w_ark = w_sb ^ w_rk_prev;
  for (c = 0; c < 4; c++) begin : g_mix
    assign w_mix[127-32*c -: 32] = inv_mix_column(w_ark[127-32*c -: 32]);
  end
  // Held low during reset so nothing is accepted while the core is being cleared.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign plaintext = r_pt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_rk    <= '0;
      r_pt    <= '0;
      r_rnd   <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_st    <= ciphertext ^ key_last;
      r_rk    <= key_last;
      r_rnd   <= 4'd10;
      r_state <= ROUND;
    end else if (r_state == ROUND) begin
      r_st  <= (r_rnd == 4'd1) ? w_ark : w_mix;
      r_rk  <= w_rk_prev;
      r_rnd <= r_rnd - 4'd1;
      if (r_rnd == 4'd1) begin
        r_pt    <= w_ark;
        r_state <= DONE;
      end
    end else if (r_state == DONE && out_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 decryption core: one inverse round per clock, built on a new `inv_sbox` byte-substitution table plus the existing forward `Sbox` for the key schedule. Accepts a 128-bit ciphertext and the final (round-10) encryption round key over a valid/ready handshake. Runs the key schedule backwards on the fly and returns plaintext over a second valid/ready handshake. It is the receive-side counterpart of the AES encrypt datapath.

## Interface
- No parameters; AES-128 only, 10 rounds fixed.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — ciphertext and key are valid.
- `in_ready`  out  1  — core is idle and can accept a block.
- `ciphertext`  in  128  — FIPS-197 byte order: `[127:120]` = byte 0; state is column-major.
- `key_last`  in  128  — round-10 round key from the encryption key schedule, same byte order.
- `out_valid`  out  1  — plaintext is valid.
- `out_ready`  in  1  — downstream accepts plaintext.
- `plaintext`  out  128  — result, same byte order.

## Operation
- **FSM states:** IDLE, ROUND, DONE.
  - `in_ready` = (state==IDLE).
  - `out_valid` = (state==DONE).
- **IDLE:** when `in_valid && in_ready`:
  - `st <= ciphertext ^ key_last`
  - `rk <= key_last`
  - `rnd <= 10`
  - go to ROUND.
- **ROUND:** each cycle:
  - Compute `rk_prev` from `rk` words w0..w3 (w0 = `[127:96]`):
    - `w3' = w3^w2`, `w2' = w2^w1`, `w1' = w1^w0`
    - `w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[rnd],24'h0}`
    - Rcon[10..1] = 36,1B,80,40,20,10,08,04,02,01.
  - Update the state: `st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_prev)`.
  - Update the counters: `rk <= rk_prev`, `rnd <= rnd-1`.
- **Final round:** when `rnd==1`, InvMixColumns is omitted, the result is written to `plaintext`, and the FSM goes to DONE.
- **DONE:** `plaintext` and `out_valid` are held until `out_ready`, then the FSM goes to IDLE. Inputs are ignored while not in IDLE.
- **Key-schedule S-boxes:** the four bytes of SubWord use four forward `Sbox` instances.
- **State S-boxes:** InvSubBytes uses 16 `inv_sbox` instances.
- **InvMixColumns** is per column over GF(2^8), polynomial 0x11B, coefficients {0e,0b,0d,09}, built from `xtime` chains.
- **`rnd`** is 4 bits and never wraps below 1 inside ROUND.
- **Reset**, at any time including mid-round:
  - state IDLE, `st`, `rk` and `plaintext` to 0, `rnd` to 0.
  - `out_valid` = 0.
  - `in_ready` = 0 while `rst` is high, 1 on the first cycle after release.
  - The in-flight block is discarded.

## Timing
- Accept at edge E0.
- Rounds are computed at E1..E10.
- `out_valid` is high after E10, i.e. 10 cycles after acceptance.
- The output handshake completes at the first edge with `out_ready` high, earliest E11.
- The next accept is earliest E12, giving a sustained throughput of 1 block per 12 cycles.
- `in_valid` held high during the busy period causes no accept until `in_ready` rises.
- The longest combinational path is `inv_sbox` → XOR → InvMixColumns, in parallel with `Sbox` → Rcon XOR on the key side.
- All outputs are registered or decoded directly from the state register.

## Structure
- **`aes_pkg`:**
  - FSM state enum
  - Rcon lookup function indexed by `rnd`
  - `xtime` and multiply-by-{09,0b,0d,0e} functions
  - `inv_shift_rows` and `inv_mix_column` functions
- **`inv_sbox`:** new combinational sub-module, 8-bit `in` → 8-bit `out`, the FIPS-197 inverse S-box (e.g. 00→52, 63→00, 16→FF).
- **Reused:** the existing forward `Sbox` module, unchanged.
- **`aes_inv_cipher`:** holds the FSM, `st`, `rk`, `rnd` and `plaintext` registers.

## Test plan
- **FIPS-197 C.1 vector:**
  - Stimulus: `ciphertext` 69c4e0d86a7b0430d8cdb78070b4c55a, `key_last` 13111d7fe3944a17f307a78b4d2b30c5, `out_ready` high.
  - Required: `plaintext` 00112233445566778899aabbccddeeff with `out_valid` rising exactly 10 cycles after accept, and `in_ready` high again at E12.
- **FIPS-197 App. B vector:**
  - Stimulus: `ciphertext` 3925841d02dc09fbdc118597196a0b32, `key_last` d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: `plaintext` 3243f6a8885a308d313198a2e0370734.
- **Backpressure:**
  - Stimulus: C.1 vector with `out_ready` low for 5 cycles after `out_valid` rises.
  - Required: `plaintext` stable, `out_valid` high and `in_ready` low throughout; handshake on the first `out_ready` edge.
- **Back-to-back:**
  - Stimulus: `in_valid` held high, B vector presented immediately after C.1.
  - Required: the second accept occurs at E12 exactly, and both results are correct and in order.
- **Reset mid-operation:**
  - Stimulus: assert `rst` for 1 cycle at `rnd`==5.
  - Required: `out_valid` 0 and `plaintext` 0 after reset; `in_ready` 1 the next cycle; a fresh C.1 vector then decrypts correctly.
- **`inv_sbox` exhaustive:**
  - Stimulus: all 256 x.
  - Required: `inv_sbox(Sbox(x))==x`, plus spot values 00→52 and 63→00.
